// File: rtl/pa_block_mover_pkg.sv
// Shared types for the page-allocator block mover: handle layout and FSM state encoding.
package pa_pkg;

  localparam int PA_LANE_FIFO_ADDR_W    = 5;
  localparam int PA_HANDLE_ADDR_W       = 10;
  localparam int PA_PAGE_ADDR_W         = 18;
  localparam int PA_MAX_PKT_LENGTH_BITS = 8;
  localparam int PA_DATA_W              = 40;
  localparam int PA_HANDLE_W = PA_LANE_FIFO_ADDR_W + PA_PAGE_ADDR_W + PA_MAX_PKT_LENGTH_BITS + 1;

  // Handle fields, LSB first.
  localparam int PA_LANE_START_LSB = 0;
  localparam int PA_PAGE_START_LSB = PA_LANE_START_LSB + PA_LANE_FIFO_ADDR_W;
  localparam int PA_LEN_LSB        = PA_PAGE_START_LSB + PA_PAGE_ADDR_W;
  localparam int PA_SKIP_BIT       = PA_LEN_LSB + PA_MAX_PKT_LENGTH_BITS;

  typedef struct packed {
    logic                              skip;
    logic [PA_MAX_PKT_LENGTH_BITS-1:0] len;
    logic [PA_PAGE_ADDR_W-1:0]         page_start;
    logic [PA_LANE_FIFO_ADDR_W-1:0]    lane_start;
  } pa_handle_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_MOVE,
    ST_DRAIN,
    ST_RETIRE
  } pa_mover_state_e;

endpackage

// File: rtl/pa_block_mover_if.sv
// Shared page RAM write port: request/grant handshake plus the write strobe, address and data.
interface pa_page_wr_if #(
  parameter int PAGE_ADDR_W = pa_pkg::PA_PAGE_ADDR_W,
  parameter int DATA_W      = pa_pkg::PA_DATA_W
);
  logic                   page_wr_req;
  logic                   page_wr_gnt;
  logic                   page_we;
  logic [PAGE_ADDR_W-1:0] page_waddr;
  logic [DATA_W-1:0]      page_wdata;

  modport master (
    output page_wr_req, page_we, page_waddr, page_wdata,
    input  page_wr_gnt
  );

  modport slave (
    input  page_wr_req, page_we, page_waddr, page_wdata,
    output page_wr_gnt
  );
endinterface

// File: rtl/pa_block_mover_stats.sv
// Packet, word and skip counters for the block mover; only built when PA_MOVER_STATS_EN is defined.
module pa_mover_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_inc,
  input  logic        word_inc,
  input  logic        skip_inc,
  output logic [31:0] stat_pkt_cnt,
  output logic [31:0] stat_word_cnt,
  output logic [31:0] stat_skip_cnt
);

  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] skip_cnt_q, skip_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q  + {31'd0, pkt_inc};
    word_cnt_d = word_cnt_q + {31'd0, word_inc};
    skip_cnt_d = skip_cnt_q + {31'd0, skip_inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      word_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      word_cnt_q <= word_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_word_cnt = word_cnt_q;
  assign stat_skip_cnt = skip_cnt_q;

endmodule

// File: rtl/pa_block_mover.sv
// Per-lane handle consumer: copies each packet from the lane FIFO into page RAM, then releases it.
// Optional statistics counters are built when PA_MOVER_STATS_EN is defined.
module pa_block_mover
  import pa_pkg::*;
#(
  parameter int LANE_FIFO_ADDR_W    = PA_LANE_FIFO_ADDR_W,
  parameter int HANDLE_ADDR_W       = PA_HANDLE_ADDR_W,
  parameter int PAGE_ADDR_W         = PA_PAGE_ADDR_W,
  parameter int MAX_PKT_LENGTH_BITS = PA_MAX_PKT_LENGTH_BITS,
  parameter int DATA_W              = PA_DATA_W,
  parameter int HANDLE_W            = LANE_FIFO_ADDR_W + PAGE_ADDR_W + MAX_PKT_LENGTH_BITS + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [HANDLE_ADDR_W-1:0]    handle_wptr,
  output logic [HANDLE_ADDR_W-1:0]    handle_raddr,
  input  logic [HANDLE_W-1:0]         handle_rd_data,
  output logic [HANDLE_ADDR_W-1:0]    handle_rptr,
  output logic [LANE_FIFO_ADDR_W-1:0] lane_raddr,
  input  logic [DATA_W-1:0]           lane_rd_data,
  output logic [LANE_FIFO_ADDR_W-1:0] lane_rptr,
  pa_page_wr_if.master                page_if,
  output logic                        mover_busy,
  output logic [31:0]                 stat_pkt_cnt,
  output logic [31:0]                 stat_word_cnt,
  output logic [31:0]                 stat_skip_cnt
);

  localparam int PAGE_START_LSB = LANE_FIFO_ADDR_W;
  localparam int LEN_LSB        = PAGE_START_LSB + PAGE_ADDR_W;
  localparam int SKIP_BIT       = LEN_LSB + MAX_PKT_LENGTH_BITS;

  pa_mover_state_e                state_q, state_d;
  logic [LANE_FIFO_ADDR_W-1:0]    lane_start_q, lane_start_d;
  logic [PAGE_ADDR_W-1:0]         page_start_q, page_start_d;
  logic [MAX_PKT_LENGTH_BITS-1:0] len_q, len_d;
  logic                           skip_q, skip_d;
  logic [MAX_PKT_LENGTH_BITS-1:0] k_q, k_d;
  logic [HANDLE_ADDR_W-1:0]       handle_rptr_q, handle_rptr_d;
  logic [LANE_FIFO_ADDR_W-1:0]    lane_rptr_q, lane_rptr_d;
  logic                           page_wr_req_q, page_wr_req_d;
  logic                           page_we_q, page_we_d;
  logic [PAGE_ADDR_W-1:0]         page_waddr_q, page_waddr_d;
  logic                           mover_busy_q, mover_busy_d;

  logic [LANE_FIFO_ADDR_W-1:0]    hdl_lane_start;
  logic [PAGE_ADDR_W-1:0]         hdl_page_start;
  logic [MAX_PKT_LENGTH_BITS-1:0] hdl_len;
  logic                           hdl_skip;
  logic                           issue;

  assign hdl_lane_start = handle_rd_data[LANE_FIFO_ADDR_W-1:0];
  assign hdl_page_start = handle_rd_data[LEN_LSB-1:PAGE_START_LSB];
  assign hdl_len        = handle_rd_data[SKIP_BIT-1:LEN_LSB];
  assign hdl_skip       = handle_rd_data[SKIP_BIT];

  // A lane read is issued in every MOVE cycle that holds the grant.
  assign issue = (state_q == ST_MOVE) && page_if.page_wr_gnt;

  always_comb begin
    // NOTE: every _d takes its held value first, so no path through the case leaves a latch.
    state_d       = state_q;
    lane_start_d  = lane_start_q;
    page_start_d  = page_start_q;
    len_d         = len_q;
    skip_d        = skip_q;
    k_d           = k_q;
    handle_rptr_d = handle_rptr_q;
    lane_rptr_d   = lane_rptr_q;
    page_we_d     = 1'b0;
    page_waddr_d  = page_waddr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (handle_rptr_q != handle_wptr) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        lane_start_d = hdl_lane_start;
        page_start_d = hdl_page_start;
        len_d        = hdl_len;
        skip_d       = hdl_skip;
        k_d          = '0;
        state_d      = (hdl_skip || hdl_len == '0) ? ST_RETIRE : ST_MOVE;
      end
      ST_MOVE: begin
        if (issue) begin
          page_we_d    = 1'b1;
          page_waddr_d = page_start_q + PAGE_ADDR_W'(k_q);
          k_d          = k_q + MAX_PKT_LENGTH_BITS'(1);
          if (k_q == len_q - MAX_PKT_LENGTH_BITS'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_RETIRE;
      ST_RETIRE: begin
        // Lane space is released for skipped packets too; their words still occupy the FIFO.
        handle_rptr_d = handle_rptr_q + HANDLE_ADDR_W'(1);
        lane_rptr_d   = lane_start_q + LANE_FIFO_ADDR_W'(len_q);
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    page_wr_req_d = (state_d == ST_MOVE) || (state_d == ST_DRAIN);
    mover_busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      lane_start_q  <= '0;
      page_start_q  <= '0;
      len_q         <= '0;
      skip_q        <= 1'b0;
      k_q           <= '0;
      handle_rptr_q <= '0;
      lane_rptr_q   <= '0;
      page_wr_req_q <= 1'b0;
      page_we_q     <= 1'b0;
      page_waddr_q  <= '0;
      mover_busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
      state_q       <= state_d;
      lane_start_q  <= lane_start_d;
      page_start_q  <= page_start_d;
      len_q         <= len_d;
      skip_q        <= skip_d;
      k_q           <= k_d;
      handle_rptr_q <= handle_rptr_d;
      lane_rptr_q   <= lane_rptr_d;
      page_wr_req_q <= page_wr_req_d;
      page_we_q     <= page_we_d;
      page_waddr_q  <= page_waddr_d;
      mover_busy_q  <= mover_busy_d;
    end
  end

  assign handle_rptr  = handle_rptr_q;
  assign handle_raddr = handle_rptr_q;
  assign lane_rptr    = lane_rptr_q;
  assign lane_raddr   = lane_start_q + LANE_FIFO_ADDR_W'(k_q);
  assign mover_busy   = mover_busy_q;

  // Lane data arrives one cycle after its read, exactly when the matching write strobe is up.
  assign page_if.page_wr_req = page_wr_req_q;
  assign page_if.page_we     = page_we_q;
  assign page_if.page_waddr  = page_waddr_q;
  assign page_if.page_wdata  = page_we_q ? lane_rd_data : '0;

`ifdef PA_MOVER_STATS_EN
  pa_mover_stats u_stats (
    .clk           (clk),
    .rst_n         (rst_n),
    .pkt_inc       ((state_q == ST_RETIRE) && !skip_q && (len_q != '0)),
    .word_inc      (page_we_q),
    .skip_inc      ((state_q == ST_RETIRE) && skip_q),
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_word_cnt (stat_word_cnt),
    .stat_skip_cnt (stat_skip_cnt)
  );
`else
  assign stat_pkt_cnt  = '0;
  assign stat_word_cnt = '0;
  assign stat_skip_cnt = '0;
`endif

endmodule
